// File: rtl/dram_multi_port_burst_ctrl.sv
// ----------------------------------------------------------------------------
// dram_multi_port_burst_ctrl
//
// Purpose
//   Main-memory bus interface between the cache level and a single-word DRAM
//   port. NUM_CH block-transfer requesters are arbitrated round-robin. Each
//   granted request moves one aligned block of BLOCK_WORDS words, using one
//   DRAM handshake per word. There is exactly one idle (GAP) cycle between
//   words, so the DRAM sees a fresh enable edge for every word. If a word is
//   not acknowledged within TIMEOUT cycles, the transfer is aborted and
//   reported on ch_err.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   reset      : asynchronous, active-high reset
//   ch_req     : per-channel request; held by the requester until done/err
//   ch_we      : per-channel direction (1 = write block, 0 = read block)
//   ch_addr    : per-channel byte address (any byte within the block)
//   ch_wdata   : per-channel write block, word 0 at index 0
//   ch_done    : one-cycle one-hot pulse; granted transfer completed
//   ch_err     : one-cycle one-hot pulse; granted transfer timed out
//   rdata      : last read block; valid in the ch_done cycle of a read
//   busy       : high whenever the controller is not idle
//   mem_addr   : DRAM word byte address (0 when no word is in flight)
//   mem_wdata  : DRAM write word (0 when no word is in flight)
//   mem_re     : DRAM read enable (level, held until mem_ack)
//   mem_we     : DRAM write enable (level, held until mem_ack)
//   mem_rdata  : DRAM read word, valid together with mem_ack
//   mem_ack    : DRAM word handshake complete
// ----------------------------------------------------------------------------
module dram_multi_port_burst_ctrl #(
   parameter int NUM_CH      = 2,
   parameter int ADDR_W      = 32,
   parameter int WORD_W      = 32,
   parameter int BLOCK_WORDS = 4,
   parameter int TIMEOUT     = 64
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic [NUM_CH-1:0]                          ch_req,
   input  logic [NUM_CH-1:0]                          ch_we,
   input  logic [NUM_CH-1:0][ADDR_W-1:0]              ch_addr,
   input  logic [NUM_CH-1:0][BLOCK_WORDS-1:0][WORD_W-1:0] ch_wdata,
   output logic [NUM_CH-1:0]                          ch_done,
   output logic [NUM_CH-1:0]                          ch_err,
   output logic [BLOCK_WORDS-1:0][WORD_W-1:0]         rdata,
   output logic                                       busy,
   output logic [ADDR_W-1:0]                          mem_addr,
   output logic [WORD_W-1:0]                          mem_wdata,
   output logic                                       mem_re,
   output logic                                       mem_we,
   input  logic [WORD_W-1:0]                          mem_rdata,
   input  logic                                       mem_ack
);

   localparam int GW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int IW    = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
   localparam int TW    = $clog2(TIMEOUT);
   localparam int BYTES = WORD_W / 8;
   localparam int OFF   = $clog2(BLOCK_WORDS * BYTES);
   // Clears the byte-within-block bits, so any address in a block maps to its base.
   localparam logic [ADDR_W-1:0] BLK_MASK = ~((ADDR_W'(1) << OFF) - ADDR_W'(1));

   typedef enum logic [2:0] {
      S_IDLE,
      S_XFER,
      S_GAP,
      S_DONE,
      S_ERR
   } state_t;

   state_t                              state_q,    state_d;
   logic [GW-1:0]                       grant_q,    grant_d;
   logic [GW-1:0]                       last_q,     last_d;
   logic                                we_q,       we_d;
   logic [ADDR_W-1:0]                   base_q,     base_d;
   logic [BLOCK_WORDS-1:0][WORD_W-1:0]  wdata_q,    wdata_d;
   logic [IW-1:0]                       word_idx_q, word_idx_d;
   logic [TW-1:0]                       timer_q,    timer_d;
   logic [BLOCK_WORDS-1:0][WORD_W-1:0]  rdata_q;

   logic          req_hit;
   logic [GW-1:0] pick;
   int            cand;
   logic          rd_wr_en;
   logic          in_xfer;

   // ------------------------------------------------------------------------
   // Round-robin pick. Offsets are scanned from the farthest to the nearest,
   // so the channel right after last_q wins. Offset NUM_CH is last_q itself,
   // which therefore has the lowest priority. A channel that re-requests in
   // its own done cycle therefore loses to any other pending channel.
   // ------------------------------------------------------------------------
   always_comb begin
      req_hit = 1'b0;
      pick    = last_q;
      cand    = 0;
      for (int off = NUM_CH; off >= 1; off--) begin
         cand = (int'(last_q) + off) % NUM_CH;
         if (ch_req[GW'(cand)]) begin
            req_hit = 1'b1;
            pick    = GW'(cand);
         end
      end
   end

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and datapath-update logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_d     = last_q;
      we_d       = we_q;
      base_d     = base_q;
      wdata_d    = wdata_q;
      word_idx_d = word_idx_q;
      timer_d    = timer_q;
      rd_wr_en   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_hit) begin
               // Latch the whole request so that later changes on the
               // channel inputs cannot disturb the transfer in flight.
               grant_d    = pick;
               base_d     = ch_addr[pick] & BLK_MASK;
               we_d       = ch_we[pick];
               wdata_d    = ch_wdata[pick];
               word_idx_d = '0;
               timer_d    = '0;
               state_d    = S_XFER;
            end
         end

         S_XFER: begin
            if (mem_ack) begin
               rd_wr_en = !we_q;
               if (word_idx_q == IW'(BLOCK_WORDS - 1)) begin
                  state_d = S_DONE;
               end else begin
                  word_idx_d = word_idx_q + IW'(1);
                  state_d    = S_GAP;
               end
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               // This was the TIMEOUT-th unacknowledged cycle for this word.
               state_d = S_ERR;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end

         S_GAP: begin
            timer_d = '0;
            state_d = S_XFER;
         end

         S_DONE, S_ERR: begin
            last_d  = grant_q;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant_q    <= '0;
         last_q     <= GW'(NUM_CH - 1);
         we_q       <= 1'b0;
         base_q     <= '0;
         wdata_q    <= '0;
         word_idx_q <= '0;
         timer_q    <= '0;
      end else begin
         grant_q    <= grant_d;
         last_q     <= last_d;
         we_q       <= we_d;
         base_q     <= base_d;
         wdata_q    <= wdata_d;
         word_idx_q <= word_idx_d;
         timer_q    <= timer_d;
      end
   end

   // Read block capture. Only the word currently being acknowledged is
   // written. Each word keeps its value until a later read overwrites it.
   generate
      for (genvar gi = 0; gi < BLOCK_WORDS; gi++) begin : g_rdata
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               rdata_q[gi] <= '0;
            end else if (rd_wr_en && (word_idx_q == IW'(gi))) begin
               rdata_q[gi] <= mem_rdata;
            end
         end
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Outputs. These are decoded from state, so an asynchronous reset clears
   // them at once.
   // ------------------------------------------------------------------------
   assign in_xfer   = (state_q == S_XFER);
   assign busy      = (state_q != S_IDLE);
   assign mem_re    = in_xfer && !we_q;
   assign mem_we    = in_xfer && we_q;
   // The address add wraps modulo 2^ADDR_W.
   assign mem_addr  = in_xfer ? (base_q + (ADDR_W'(word_idx_q) * ADDR_W'(BYTES))) : '0;
   assign mem_wdata = in_xfer ? wdata_q[word_idx_q] : '0;
   assign rdata     = rdata_q;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_pulse
         assign ch_done[gi] = (state_q == S_DONE) && (grant_q == GW'(gi));
         assign ch_err[gi]  = (state_q == S_ERR)  && (grant_q == GW'(gi));
      end
   endgenerate

endmodule
